// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: a program-load write port plus a fixed-latency
// fetch pipeline that returns one- or two-word instructions.
// A request is accepted in IDLE (or in RESP while the response is being
// consumed), the first word is checked for the long-instruction bit in CHK,
// and the assembled {lo, hi} pair is presented in RESP until rsp_ready.
module instr_fetch_mem #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 10,
    parameter int LONG_BIT      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_en,
    input  logic [ADDRESS_SPACE-1:0]   ld_addr,
    input  logic [WORD_LENGTH-1:0]     ld_data,
    input  logic                       req_valid,
    input  logic [ADDRESS_SPACE-1:0]   req_pc,
    output logic                       req_ready,
    input  logic                       flush,
    output logic                       rsp_valid,
    output logic [2*WORD_LENGTH-1:0]   rsp_instr,
    output logic                       rsp_long,
    output logic [ADDRESS_SPACE-1:0]   rsp_next_pc,
    input  logic                       rsp_ready
);

    localparam int DEPTH = 2**ADDRESS_SPACE;
    localparam logic [ADDRESS_SPACE-1:0] ONE = ADDRESS_SPACE'(1);
    localparam logic [ADDRESS_SPACE-1:0] TWO = ADDRESS_SPACE'(2);

    typedef enum logic [1:0] {IDLE, CHK, RESP} state_t;

    state_t                   state, state_nxt;
    logic [WORD_LENGTH-1:0]   mem [DEPTH];
    logic [WORD_LENGTH-1:0]   lo, hi;
    logic [ADDRESS_SPACE-1:0] pc_q;
    logic                     accept;

    assign accept = req_valid & req_ready;

    // Program load port; memory is never cleared and ignores loads in reset.
    // Nonblocking write gives read-first behaviour against a same-edge fetch.
    always_ff @(posedge clk) begin
        if (reset && ld_en)
            mem[ld_addr] <= ld_data;
    end

    // Next-state and handshake outputs; flush blocks acceptance and returns to IDLE.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (accept) state_nxt = CHK;
            end
            CHK: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready && !flush;
                if (rsp_ready) state_nxt = accept ? CHK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State register and fetch datapath; lo/pc_q capture on accept, hi on CHK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            pc_q     <= '0;
            rsp_long <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lo   <= mem[req_pc];
                pc_q <= req_pc;
            end else if (state == CHK && !flush) begin
                if (lo[LONG_BIT]) begin
                    hi       <= mem[pc_q + ONE];
                    rsp_long <= 1'b1;
                end else begin
                    hi       <= '0;
                    rsp_long <= 1'b0;
                end
            end
        end
    end

    // Response view: address arithmetic wraps naturally at ADDRESS_SPACE bits.
    always_comb begin
        rsp_instr   = {lo, hi};
        rsp_next_pc = pc_q + (rsp_long ? TWO : ONE);
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
Parameters:
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, giving the memory word width in bits.
REQ-002 The block SHALL have parameter ADDRESS_SPACE, default 10, giving the address width; depth is 2**ADDRESS_SPACE words.
REQ-003 The block SHALL have parameter LONG_BIT, default 0, giving the bit index of the first word that marks a two-word (long) instruction when 1.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports ld_en, ld_addr and ld_data: inputs of 1, ADDRESS_SPACE and WORD_LENGTH bits forming the program-load write port.
REQ-007 The block SHALL have ports req_valid, req_pc and req_ready: req_valid and req_pc are inputs of 1 and ADDRESS_SPACE bits; req_ready is a 1-bit output; together they form the fetch request handshake.
REQ-008 The block SHALL have port flush, input, 1 bit: aborts any in-flight fetch.
REQ-009 The block SHALL have ports rsp_valid, rsp_instr, rsp_long and rsp_next_pc: outputs of 1, 2*WORD_LENGTH, 1 and ADDRESS_SPACE bits.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.

Function
REQ-011 A load write SHALL occur at a rising edge where ld_en=1: mem[ld_addr] <= ld_data. Loads are legal in any FSM state.
REQ-012 The FSM SHALL have three states: IDLE, CHK and RESP.
REQ-013 req_ready SHALL be 1 in IDLE, or in RESP when rsp_ready=1; otherwise 0.
REQ-014 On an accept edge (req_valid & req_ready & !flush): lo <= mem[req_pc], pc_q <= req_pc, state <= CHK.
REQ-015 In CHK, when lo[LONG_BIT]=1: hi <= mem[pc_q+1], with the address wrapping modulo 2**ADDRESS_SPACE, and rsp_long <= 1.
REQ-016 In CHK, when lo[LONG_BIT]=0: hi <= 0 and rsp_long <= 0.
REQ-017 From CHK the next state SHALL always be RESP.
REQ-018 Latency SHALL be fixed: rsp_valid=1 in the second cycle after the accept cycle, for both short and long instructions.
REQ-019 In RESP: rsp_valid=1 and rsp_instr = {lo, hi}, with lo in the upper half.
REQ-020 In RESP: rsp_next_pc = pc_q+1 when short and pc_q+2 when long, both modulo 2**ADDRESS_SPACE.
REQ-021 In RESP, rsp_instr, rsp_long and rsp_next_pc SHALL hold stable while rsp_ready=0.
REQ-022 In RESP with rsp_ready=1: if a new request is accepted on the same edge the state SHALL go to CHK (back-to-back, one response every 2 cycles); otherwise to IDLE.
REQ-023 rsp_valid SHALL be 0 in IDLE and CHK.
REQ-024 flush=1 SHALL force the state to IDLE on the next edge from any state, drop any pending response, and block acceptance; req_ready SHALL read 0 while flush=1.
REQ-025 A same-edge load and fetch read of the same address SHALL be read-first: the fetch returns the old word, and the write still completes.
REQ-026 rsp_valid SHALL never assert without a preceding accept that was not flushed.

Reset
REQ-027 Asserting reset=0 SHALL immediately, without waiting for clk, set state=IDLE, rsp_valid=0, rsp_long=0, lo=hi=0, pc_q=0; hence rsp_instr=0, rsp_next_pc=1 and req_ready=1 while reset=0.
REQ-028 Memory contents SHALL NOT be cleared by reset, and loads SHALL be ignored while reset=0.
REQ-029 Reset asserted mid-fetch (CHK or RESP) SHALL discard the fetch; the first response after release comes only from a fresh accept.

Verification
REQ-030 Short fetch: load mem[5]=16'h0002, accept pc=5 -> two cycles later rsp_valid=1, rsp_instr=32'h0002_0000, rsp_long=0, rsp_next_pc=6.
REQ-031 Long fetch with wrap (ADDRESS_SPACE=10): mem[1023]=16'h0001, mem[0]=16'hBEEF, accept pc=1023 -> rsp_instr=32'h0001_BEEF, rsp_long=1, rsp_next_pc=1.
REQ-032 Backpressure: hold rsp_ready=0 for 4 cycles -> rsp outputs stable and req_ready=0; raise rsp_ready with req_valid=1 -> next response exactly 2 cycles later.
REQ-033 Flush: flush=1 in CHK -> state IDLE, no rsp_valid pulse; a request held with flush=1 is not accepted.
REQ-034 Read-first collision: mem[8]=16'h0010, same edge load mem[8]=16'h0020 and accept pc=8 -> rsp_instr[31:16]=16'h0010; a following fetch of pc=8 returns 16'h0020.
REQ-035 Async reset: pull reset low mid-cycle while in RESP -> rsp_valid=0 before the next clk edge; memory contents are intact after release.
